wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
Wishbone B4 pipelined initiator that turns single command words into bus transactions on the peripheral Wishbone bus. Register slaves include the serial/DSHOT mux at 0x0400 and the DSHOT/serial cores. It sits between the SPI command decoder (upstream, valid/ready) and the Wishbone interconnect. It issues one transaction at a time and returns a response word (read data or error) over a second valid/ready channel.

Parameters:
ADDR_W, 32, Wishbone address width (byte address)
DATA_W, 32, Wishbone data width; wb_sel_o width is DATA_W/8
TIMEOUT_CYCLES, 255, bus cycles to wait for ack before aborting (used only when WB_MASTER_TIMEOUT_EN is defined); must be 1..65535

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  ADDR_W  target byte address
cmd_dat_i  in  DATA_W  write data
cmd_sel_i  in  DATA_W/8  byte enables
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DATA_W  read data; 0 for writes and errors
rsp_err_o  out  1  1 = transaction timed out
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DATA_W/8  Wishbone byte select
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_stall_i  in  1  Wishbone stall (pipelined)
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, wb_rst_ni=0): state IDLE; cmd_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_dat_o=0; wb_cyc_o=0; wb_stb_o=0; wb_we_o=0; wb_adr_o=0; wb_dat_o=0; wb_sel_o=0; busy_o=0; timeout counter=0.
- All outputs are registered. Reset asserted mid-transaction drops cyc/stb immediately, and any pending response is discarded.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch we/adr/dat/sel into the wb_*_o registers; clear the counter.
  - Next cycle: wb_cyc_o=wb_stb_o=1; go to REQ.
  - Accept-to-stb latency is 1 cycle.
- REQ:
  - cmd_ready_o=0; stb held with stable adr/dat/we/sel while wb_stall_i=1.
  - When wb_stall_i=0: stb deasserts next cycle; go to WAIT.
  - If wb_ack_i=1 in the same cycle (zero-wait slave), go directly to RESP.
  - wb_ack_i with wb_stall_i=1 is also treated as completion: go to RESP.
- WAIT: cyc=1, stb=0. On wb_ack_i, go to RESP.
- Completion (ack seen in REQ or WAIT):
  - Next cycle: cyc=stb=0; rsp_valid_o=1; rsp_err_o=0.
  - rsp_dat_o = wb_dat_i sampled on the ack cycle for reads, 0 for writes.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o held stable until rsp_ready_i=1.
  - On handshake: rsp_valid_o=0 and go to IDLE. cmd_ready_o=1 on the following cycle; no command overlap with a pending response.
- wb_ack_i seen in IDLE or RESP (stray or late ack) is ignored.
- With a 1-cycle registered-ack slave and rsp_ready_i tied high: accept@T, stb@T+1, ack@T+2, rsp_valid@T+3, cmd_ready@T+4.

Optional Feature:
WB_MASTER_TIMEOUT_EN
- Defined:
  - A 16-bit counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without ack: drop cyc/stb next cycle; go to RESP with rsp_err_o=1 and rsp_dat_o=0.
  - If ack and timeout coincide, the ack wins (normal response).
- Not defined: no counter is instantiated, rsp_err_o is tied 0, and the master waits indefinitely for ack.

Decomposition:
- Package wb_master_pkg:
  - state enum: IDLE, REQ, WAIT, RESP
  - wb_cmd_t struct (we, adr, dat, sel)
  - constant WB_SEL_W = DATA_W/8
  - constant RSP_ERR_DATA = 0
- No sub-module; the counter and FSM are a single always_ff plus next-state logic.

Test Plan:
- Write to mux register: cmd we=1, adr=0x0400, dat=1, sel=0xF against a registered-ack slave model → one stb cycle with adr=0x0400, dat=1, we=1; rsp_valid 3 cycles after accept; rsp_dat=0, rsp_err=0; slave register=1.
- Read back: cmd we=0, adr=0x0400 → rsp_dat=0x00000001, rsp_err=0; exactly one cyc assertion.
- Stall: slave holds wb_stall_i=1 for 3 cycles → stb high for 4 cycles with adr/dat stable; the transaction still completes correctly.
- Backpressure: rsp_ready_i low for 5 cycles after completion → rsp_valid/rsp_dat held stable; cmd_ready_o=0 throughout; cmd_ready_o=1 the cycle after the handshake.
- Timeout (macro defined, TIMEOUT_CYCLES=8): no ack → cyc drops, rsp_err=1, rsp_dat=0. A later stray ack is ignored and the next command works normally.
- Async reset asserted while in WAIT → cyc/stb/rsp_valid go 0 without waiting for a clock edge; after release, cmd_ready_o=1 and a new read completes correctly.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master.
//
// Contents:
//   wb_state_e   : master FSM states (idle, request, wait-for-ack, response)
//   wb_cmd_t     : one command word (we, adr, dat, sel) at the default bus widths
//   WB_SEL_W     : byte-select width for the default 32-bit data bus
//   RSP_ERR_DATA : data word returned with an error response
package wb_master_pkg;

   localparam int unsigned WB_ADDR_W    = 32;
   localparam int unsigned WB_DATA_W    = 32;
   localparam int unsigned WB_SEL_W     = WB_DATA_W / 8;
   localparam int unsigned RSP_ERR_DATA = 0;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StResp
   } wb_state_e;

   typedef struct packed {
      logic                 we;
      logic [WB_ADDR_W-1:0] adr;
      logic [WB_DATA_W-1:0] dat;
      logic [WB_SEL_W-1:0]  sel;
   } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined initiator: turns one command word into one bus transaction and
// returns a response word (read data, or an error flag) on a second valid/ready channel.
// Only one transaction is ever outstanding; a new command is accepted only after the
// previous response has been consumed.
//
// Build option:
//   WB_MASTER_TIMEOUT_EN - when defined, a 16-bit counter aborts a transaction that sees no
//                          ack within TIMEOUT_CYCLES cycles and returns rsp_err_o=1. When
//                          undefined, no counter exists, rsp_err_o is 0 and the master waits
//                          for ack indefinitely.
//
// Ports:
//   wb_clk_i, wb_rst_ni          : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o      : command handshake; cmd_we_i/adr_i/dat_i/sel_i payload
//   rsp_valid_o/rsp_ready_i      : response handshake; rsp_dat_o, rsp_err_o payload
//   wb_adr_o/dat_o/we_o/sel_o    : Wishbone request payload
//   wb_cyc_o, wb_stb_o           : Wishbone cycle / strobe
//   wb_dat_i, wb_ack_i, wb_stall_i : Wishbone read data, acknowledge, pipelined stall
//   busy_o                       : high whenever the master is not idle
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,

   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [ADDR_W-1:0]   cmd_adr_i,
   input  logic [DATA_W-1:0]   cmd_dat_i,
   input  logic [DATA_W/8-1:0] cmd_sel_i,

   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_dat_o,
   output logic                rsp_err_o,

   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_we_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_stall_i,

   output logic                busy_o
);

   localparam int unsigned SelW = DATA_W / 8;

   wb_state_e         r_state,     w_state_nxt;
   logic              r_cmd_ready, w_cmd_ready_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_dat,   w_rsp_dat_nxt;
   logic              r_cyc,       w_cyc_nxt;
   logic              r_stb,       w_stb_nxt;
   logic              r_we,        w_we_nxt;
   logic [ADDR_W-1:0] r_adr,       w_adr_nxt;
   logic [DATA_W-1:0] r_dat,       w_dat_nxt;
   logic [SelW-1:0]   r_sel,       w_sel_nxt;
   logic              r_busy,      w_busy_nxt;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   logic              r_rsp_err,   w_rsp_err_nxt;
   logic [15:0]       r_cnt,       w_cnt_nxt;
   logic              w_timeout;

   // r_cnt counts cycles already spent in REQ/WAIT, so this fires on the
   // TIMEOUT_CYCLES-th such cycle.
   assign w_timeout = (r_cnt == TimeoutLast);
`else
   logic              w_unused_timeout;

   assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_cmd_ready_nxt = r_cmd_ready;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_dat_nxt   = r_rsp_dat;
      w_cyc_nxt       = r_cyc;
      w_stb_nxt       = r_stb;
      w_we_nxt        = r_we;
      w_adr_nxt       = r_adr;
      w_dat_nxt       = r_dat;
      w_sel_nxt       = r_sel;
      w_busy_nxt      = r_busy;
`ifdef WB_MASTER_TIMEOUT_EN
      w_rsp_err_nxt   = r_rsp_err;
      w_cnt_nxt       = r_cnt;
`endif

      unique case (r_state)
         StIdle: begin
            if (cmd_valid_i) begin
               w_we_nxt        = cmd_we_i;
               w_adr_nxt       = cmd_adr_i;
               w_dat_nxt       = cmd_dat_i;
               w_sel_nxt       = cmd_sel_i;
               w_cyc_nxt       = 1'b1;
               w_stb_nxt       = 1'b1;
               w_cmd_ready_nxt = 1'b0;
               w_busy_nxt      = 1'b1;
               w_state_nxt     = StReq;
`ifdef WB_MASTER_TIMEOUT_EN
               w_cnt_nxt       = '0;
`endif
            end
         end

         StReq, StWait: begin
`ifdef WB_MASTER_TIMEOUT_EN
            w_cnt_nxt = r_cnt + 16'd1;
`endif
            // Ack wins over stall and over a coinciding timeout.
            if (wb_ack_i) begin
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_dat_nxt   = r_we ? '0 : wb_dat_i;
               w_state_nxt     = StResp;
`ifdef WB_MASTER_TIMEOUT_EN
               w_rsp_err_nxt   = 1'b0;
            end else if (w_timeout) begin
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_dat_nxt   = DATA_W'(RSP_ERR_DATA);
               w_rsp_err_nxt   = 1'b1;
               w_state_nxt     = StResp;
`endif
            end else if ((r_state == StReq) && !wb_stall_i) begin
               w_stb_nxt   = 1'b0;
               w_state_nxt = StWait;
            end
         end

         StResp: begin
            if (rsp_ready_i) begin
               w_rsp_valid_nxt = 1'b0;
               w_rsp_dat_nxt   = '0;
               w_cmd_ready_nxt = 1'b1;
               w_busy_nxt      = 1'b0;
               w_state_nxt     = StIdle;
`ifdef WB_MASTER_TIMEOUT_EN
               w_rsp_err_nxt   = 1'b0;
`endif
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state     <= StIdle;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_dat   <= '0;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_sel       <= '0;
         r_busy      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_dat   <= w_rsp_dat_nxt;
         r_cyc       <= w_cyc_nxt;
         r_stb       <= w_stb_nxt;
         r_we        <= w_we_nxt;
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_sel       <= w_sel_nxt;
         r_busy      <= w_busy_nxt;
`ifdef WB_MASTER_TIMEOUT_EN
         r_rsp_err   <= w_rsp_err_nxt;
         r_cnt       <= w_cnt_nxt;
`endif
      end
   end

   assign cmd_ready_o = r_cmd_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_dat_o   = r_rsp_dat;
`ifdef WB_MASTER_TIMEOUT_EN
   assign rsp_err_o   = r_rsp_err;
`else
   assign rsp_err_o   = 1'b0;
`endif
   assign wb_adr_o    = r_adr;
   assign wb_dat_o    = r_dat;
   assign wb_we_o     = r_we;
   assign wb_sel_o    = r_sel;
   assign wb_cyc_o    = r_cyc;
   assign wb_stb_o    = r_stb;
   assign busy_o      = r_busy;

endmodule
